// File: rtl/reg_share_sched.sv
// Round-robin scheduler sharing one clocked datapath unit among N_REQ requesters.
// Define REG_SHARE_SCHED_CNT_EN to add the saturating Xfer_Cnt completion counter.
module reg_share_sched #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 6,
    parameter int LAT   = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Data,
    output logic [N_REQ-1:0]       Gnt,
    output logic [N_REQ-1:0]       Done,
    output logic [WIDTH-1:0]       Result,
    output logic                   Busy,
    output logic [WIDTH-1:0]       Dp_In,
    input  logic [WIDTH-1:0]       Dp_Out
`ifdef REG_SHARE_SCHED_CNT_EN
    ,
    output logic [7:0]             Xfer_Cnt
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   dpin_q, dpin_d;
    logic [7:0]         xfer_q, xfer_d;

    logic               sel_vld;
    logic [IW-1:0]      sel_idx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
        if (int'(k) == N_REQ - 1) return '0;
        return IW'(int'(k) + 1);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] k);
        return {{(N_REQ-1){1'b0}}, 1'b1} << k;
    endfunction

    // Scan downward so the set bit closest at/after the pointer wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr_q) + i) % N_REQ;
            if (Req[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        dpin_d   = dpin_q;
        xfer_d   = xfer_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gidx_d  = sel_idx;
                    gnt_d   = onehot(sel_idx);
                    dpin_d  = Data[int'(sel_idx)*WIDTH +: WIDTH];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A dropped request abandons the transaction silently.
                if (!Req[gidx_q]) begin
                    gnt_d   = '0;
                    ptr_d   = next_idx(gidx_q);
                    state_d = IDLE;
                end else if (cnt_q == CW'(LAT)) begin
                    result_d = Dp_Out;
                    done_d   = onehot(gidx_q);
                    gnt_d    = '0;
                    ptr_d    = next_idx(gidx_q);
                    state_d  = DONE;
                    if (xfer_q != 8'hFF) xfer_d = xfer_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            dpin_q   <= '0;
            xfer_q   <= '0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            dpin_q   <= dpin_d;
            xfer_q   <= xfer_d;
        end
    end

    assign Gnt    = gnt_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign Dp_In  = dpin_q;
    assign Busy   = (state_q != IDLE);

`ifdef REG_SHARE_SCHED_CNT_EN
    assign Xfer_Cnt = xfer_q;
`else
    logic unused_xfer;
    assign unused_xfer = ^xfer_q;
`endif

endmodule

// File: tb/tb_reg_share_sched.sv
// Directed bench for reg_share_sched with a LAT=1 register datapath model (Out <= In).
module tb_reg_share_sched;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [2:0] Req;
    logic [17:0] Data;
    logic [2:0] Gnt, Done;
    logic [5:0] Result, Dp_In, dp_out;
    logic       Busy;
`ifdef REG_SHARE_SCHED_CNT_EN
    logic [7:0] Xfer_Cnt;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    reg_share_sched #(.N_REQ(3), .WIDTH(6), .LAT(1)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Req    (Req),
        .Data   (Data),
        .Gnt    (Gnt),
        .Done   (Done),
        .Result (Result),
        .Busy   (Busy),
        .Dp_In  (Dp_In),
        .Dp_Out (dp_out)
`ifdef REG_SHARE_SCHED_CNT_EN
        ,
        .Xfer_Cnt (Xfer_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) dp_out <= Dp_In;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2);
        Data = {d2, d1, d0};
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] exp);
`ifdef REG_SHARE_SCHED_CNT_EN
        chk(tag, Xfer_Cnt, exp);
`endif
    endtask

    initial begin
        logic [2:0] exp_g [4];
        logic [5:0] exp_r [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_r = '{6'd32, 6'd24, 6'd7, 6'd32};

        Rst_n = 1'b1;
        Req   = '0;
        Data  = '0;
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_gnt", 8'(Gnt), 8'd0);
        chk("rst_done", 8'(Done), 8'd0);
        chk("rst_result", 8'(Result), 8'd0);
        chk("rst_busy", 8'(Busy), 8'd0);
        chk("rst_dpin", 8'(Dp_In), 8'd0);
        chk_cnt("rst_cnt", 8'd0);
        tick();
        #2 Rst_n = 1'b1;

        // Contention: all three requesting, round-robin 0,1,2,0
        set_data(6'd32, 6'd24, 6'd7);
        Req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("cont_gnt", 8'(Gnt), 8'(exp_g[t]));
            chk("cont_busy", 8'(Busy), 8'd1);
            tick();
            chk("cont_nodone", 8'(Done), 8'd0);
            tick();
            chk("cont_done", 8'(Done), 8'(exp_g[t]));
            chk("cont_result", 8'(Result), 8'(exp_r[t]));
            chk("cont_gnt_off", 8'(Gnt), 8'd0);
            if (t == 3) Req = 3'b000;
            tick();
            chk("cont_done_off", 8'(Done), 8'd0);
            chk("cont_idle", 8'(Busy), 8'd0);
        end
        chk_cnt("cont_cnt", 8'd4);

        // Abort: requester 1 drops its request mid-RUN; pointer moves to 2
        Req = 3'b010;
        tick();
        chk("abt_gnt", 8'(Gnt), 8'b010);
        Req = 3'b101;
        tick();
        chk("abt_gnt_off", 8'(Gnt), 8'd0);
        chk("abt_nodone", 8'(Done), 8'd0);
        chk("abt_busy", 8'(Busy), 8'd0);
        chk("abt_result", 8'(Result), 8'd32);
        chk_cnt("abt_cnt", 8'd4);
        tick();
        chk("abt_next_gnt", 8'(Gnt), 8'b100);
        tick();
        tick();
        chk("abt_next_done", 8'(Done), 8'b100);
        chk("abt_next_result", 8'(Result), 8'd7);
        Req = 3'b000;
        tick();
        chk_cnt("abt_next_cnt", 8'd5);

        // Operand latch: Data0 changes after grant, Dp_In must keep 32
        Req = 3'b001;
        tick();
        chk("lat_gnt", 8'(Gnt), 8'b001);
        chk("lat_dpin0", 8'(Dp_In), 8'd32);
        set_data(6'd24, 6'd24, 6'd7);
        tick();
        chk("lat_dpin1", 8'(Dp_In), 8'd32);
        tick();
        chk("lat_done", 8'(Done), 8'b001);
        chk("lat_result", 8'(Result), 8'd32);
        tick();
        chk("lat_busy", 8'(Busy), 8'd0);
        chk_cnt("lat_cnt", 8'd6);

        // Continuous single requester re-granted every LAT+3 cycles
        set_data(6'd32, 6'd24, 6'd7);
        tick();
        chk("cont1_regnt", 8'(Gnt), 8'b001);
        tick();
        tick();
        chk("cont1_done", 8'(Done), 8'b001);
        Req = 3'b000;
        tick();

        // Async reset mid-RUN, then pointer must be back at 0
        Req = 3'b010;
        tick();
        chk("ar_gnt", 8'(Gnt), 8'b010);
        #2 Rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 8'(Gnt), 8'd0);
        chk("ar_done0", 8'(Done), 8'd0);
        chk("ar_busy0", 8'(Busy), 8'd0);
        chk("ar_dpin0", 8'(Dp_In), 8'd0);
        chk("ar_result0", 8'(Result), 8'd0);
        chk_cnt("ar_cnt0", 8'd0);
        #1 Rst_n = 1'b1;
        Req = 3'b101;
        tick();
        chk("ar_regnt", 8'(Gnt), 8'b001);
        chk("ar_dpin", 8'(Dp_In), 8'd32);
        tick();
        tick();
        chk("ar_done", 8'(Done), 8'b001);
        chk("ar_result", 8'(Result), 8'd32);
        Req = 3'b000;
        tick();
        chk_cnt("ar_cnt", 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
